reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement queue between dispatch and the register map.
- Allocates a tag (entry index) per dispatched instruction and drives the register map's tag-write port.
- Captures results from the common data bus (CDB) and forwards completed-but-unretired results to dispatch operand lookups.
- Retires one instruction per cycle from the head into the register map's destination-write port; on a mispredicted branch/exception at the head it raises a one-cycle flush with a redirect address.

Parameters:
- DATA_WIDTH, 32, result data width.
- ADDR_WIDTH, 32, PC/redirect address width.
- ROB_DEPTH, 64, number of entries (power of two); TAG_WIDTH = $clog2(ROB_DEPTH).
- REGMAP_DEPTH, 32, architectural registers; REG_ADDR_WIDTH = $clog2(REGMAP_DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_enq_en  in  1  dispatch requests allocation.
- i_enq_rdest  in  REG_ADDR_WIDTH  destination register of dispatched instruction.
- o_enq_stall  out  1  ROB full; enqueue ignored this cycle.
- o_enq_tag  out  TAG_WIDTH  tag allocated this cycle (= tail index).
- o_tag_wr_en / o_tag_wr_rdest / o_tag_wr_tag  out  1 / REG_ADDR_WIDTH / TAG_WIDTH  register map tag write.
- i_cdb_en / i_cdb_tag / i_cdb_data  in  1 / TAG_WIDTH / DATA_WIDTH  result broadcast.
- i_cdb_redirect / i_cdb_addr  in  1 / ADDR_WIDTH  result requires pipeline redirect to addr.
- i_lookup_tag[0:1]  in  TAG_WIDTH  source-operand tags from the register map.
- o_lookup_rdy[0:1] / o_lookup_data[0:1]  out  1 / DATA_WIDTH  forwarded result availability/value.
- o_dest_wr_en / o_dest_wr_rdest / o_dest_wr_data  out  1 / REG_ADDR_WIDTH / DATA_WIDTH  register map destination write (retire).
- o_flush  out  1  flush pipeline and register map ready bits.
- o_redirect_addr  out  ADDR_WIDTH  fetch redirect target, valid with o_flush.

Behaviour:
- Entry state: valid, rdy, redirect, rdest, data, addr.
- head/tail are TAG_WIDTH+1 bits with a wrap bit. Empty when the pointers are equal. Full when the indices are equal and the wrap bits differ.
- Reset: all valid/rdy = 0, head = tail = 0, every output 0. Reset mid-operation discards all entries.
- Enqueue (combinational outputs): accept = i_enq_en & ~full & ~o_flush.
  - o_tag_wr_en = accept; o_tag_wr_rdest = i_enq_rdest; o_tag_wr_tag = o_enq_tag = tail index.
  - At the edge: entry[tail] gets valid = 1, rdy = 0, redirect = 0, rdest; tail advances.
  - rdest = 0 is still allocated; the register map ignores r0 writes.
- o_enq_stall = full. No same-cycle free-slot reuse: a full ROB blocks enqueue even if retiring.
- CDB: if i_cdb_en & entry[i_cdb_tag].valid, then at the edge data/redirect/addr are written and rdy = 1. CDB to an invalid entry is ignored.
- Lookup (combinational): if i_cdb_en & i_cdb_tag == i_lookup_tag[i], output rdy = 1 with data = i_cdb_data (bypass). Otherwise output rdy/data of entry[i_lookup_tag[i]]. An invalid entry gives rdy = 0.
- Retire (combinational, one per cycle) when entry[head].valid & rdy:
  - o_dest_wr_en = 1 with that entry's rdest/data.
  - At the edge: entry invalidated, head advances.
  - A CDB write to the head entry in the same cycle does not retire until the next cycle.
- Redirect at retire: if the head entry is rdy & redirect, the dest write still occurs and o_flush = 1 with o_redirect_addr = entry addr, for exactly that cycle.
  - At the edge: all entries invalid, head = tail = 0.
  - Any enqueue that cycle is dropped (o_tag_wr_en forced 0).
  - CDB writes that cycle are discarded.
- Latency: CDB at cycle N → earliest retire at N+1; flush visible the same cycle as the retire.

Test Plan:
- Reset, enqueue rdest=5 → o_tag_wr_en=1, tag=0, o_enq_stall=0; lookup tag 0 → rdy=0.
- Enqueue tags 0,1; CDB tag 1 data 0xBEEF, then tag 0 data 0x1234 → retires in order: rd of tag 0 gets 0x1234, then tag 1 gets 0xBEEF on the following cycle.
- Lookup tag 3 while CDB broadcasts tag 3 data 0xAA → o_lookup_rdy=1, data=0xAA the same cycle.
- Fill 64 entries → o_enq_stall=1; the 65th enqueue is ignored, tail unchanged; retire one → stall drops the next cycle; pointers wrap correctly.
- Entry 2 completes with redirect addr 0x400 while entries 3–5 are pending and dispatch enqueues → at retire o_flush=1, o_redirect_addr=0x400, dest written, enqueue dropped; next cycle empty, new tag=0.
- Assert rst mid-stream with completed entries → outputs 0 immediately, no retire after release.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates a tag per dispatched instruction, collects CDB results,
// forwards completed results to operand lookups and retires from the head, flushing on redirect.
module reorder_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ROB_DEPTH       = 64,
  parameter int REGMAP_DEPTH    = 32,
  localparam int TAG_WIDTH      = $clog2(ROB_DEPTH),
  localparam int REG_ADDR_WIDTH = $clog2(REGMAP_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enq_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_enq_rdest,
  output logic                      o_enq_stall,
  output logic [TAG_WIDTH-1:0]      o_enq_tag,
  output logic                      o_tag_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] o_tag_wr_rdest,
  output logic [TAG_WIDTH-1:0]      o_tag_wr_tag,
  input  logic                      i_cdb_en,
  input  logic [TAG_WIDTH-1:0]      i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]     i_cdb_data,
  input  logic                      i_cdb_redirect,
  input  logic [ADDR_WIDTH-1:0]     i_cdb_addr,
  input  logic [TAG_WIDTH-1:0]      i_lookup_tag  [2],
  output logic                      o_lookup_rdy  [2],
  output logic [DATA_WIDTH-1:0]     o_lookup_data [2],
  output logic                      o_dest_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] o_dest_wr_rdest,
  output logic [DATA_WIDTH-1:0]     o_dest_wr_data,
  output logic                      o_flush,
  output logic [ADDR_WIDTH-1:0]     o_redirect_addr
);

  localparam logic [TAG_WIDTH:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

  logic [TAG_WIDTH:0]          head;
  logic [TAG_WIDTH:0]          tail;
  logic [ROB_DEPTH-1:0]        ent_valid;
  logic [ROB_DEPTH-1:0]        ent_rdy;
  logic [ROB_DEPTH-1:0]        ent_redir;
  logic [REG_ADDR_WIDTH-1:0]   ent_rdest [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]       ent_data  [ROB_DEPTH];
  logic [ADDR_WIDTH-1:0]       ent_addr  [ROB_DEPTH];

  logic [TAG_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0] tail_idx;
  logic                 full;
  logic                 retire;
  logic                 flush;
  logic                 accept;
  logic                 cdb_hit;

  assign head_idx = head[TAG_WIDTH-1:0];
  assign tail_idx = tail[TAG_WIDTH-1:0];
  assign full     = (head_idx == tail_idx) && (head[TAG_WIDTH] != tail[TAG_WIDTH]);
  assign retire   = ent_valid[head_idx] & ent_rdy[head_idx];
  assign flush    = retire & ent_redir[head_idx];
  assign accept   = i_enq_en & ~full & ~flush;
  // A flushing cycle discards any result broadcast alongside it.
  assign cdb_hit  = i_cdb_en & ent_valid[i_cdb_tag] & ~flush;

  // Pointer and per-entry status bits; a flush empties the queue and rewinds to tag 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= {(TAG_WIDTH+1){1'b0}};
      tail      <= {(TAG_WIDTH+1){1'b0}};
      ent_valid <= {ROB_DEPTH{1'b0}};
      ent_rdy   <= {ROB_DEPTH{1'b0}};
      ent_redir <= {ROB_DEPTH{1'b0}};
    end else if (flush) begin
      head      <= {(TAG_WIDTH+1){1'b0}};
      tail      <= {(TAG_WIDTH+1){1'b0}};
      ent_valid <= {ROB_DEPTH{1'b0}};
      ent_rdy   <= {ROB_DEPTH{1'b0}};
      ent_redir <= {ROB_DEPTH{1'b0}};
    end else begin
      if (accept) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_rdy[tail_idx]   <= 1'b0;
        ent_redir[tail_idx] <= 1'b0;
        tail                <= tail + PTR_ONE;
      end
      if (cdb_hit) begin
        ent_rdy[i_cdb_tag]   <= 1'b1;
        ent_redir[i_cdb_tag] <= i_cdb_redirect;
      end
      if (retire) begin
        ent_valid[head_idx] <= 1'b0;
        ent_rdy[head_idx]   <= 1'b0;
        head                <= head + PTR_ONE;
      end
    end
  end

  // Entry payload; only meaningful while the matching status bits are set.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_rdest[tail_idx] <= i_enq_rdest;
    end
    if (cdb_hit) begin
      ent_data[i_cdb_tag] <= i_cdb_data;
      ent_addr[i_cdb_tag] <= i_cdb_addr;
    end
  end

  // Dispatch, retire and flush outputs, forced to zero while reset is held.
  always_comb begin
    if (rst) begin
      o_enq_stall     = 1'b0;
      o_enq_tag       = {TAG_WIDTH{1'b0}};
      o_tag_wr_en     = 1'b0;
      o_tag_wr_rdest  = {REG_ADDR_WIDTH{1'b0}};
      o_tag_wr_tag    = {TAG_WIDTH{1'b0}};
      o_dest_wr_en    = 1'b0;
      o_dest_wr_rdest = {REG_ADDR_WIDTH{1'b0}};
      o_dest_wr_data  = {DATA_WIDTH{1'b0}};
      o_flush         = 1'b0;
      o_redirect_addr = {ADDR_WIDTH{1'b0}};
    end else begin
      o_enq_stall     = full;
      o_enq_tag       = tail_idx;
      o_tag_wr_en     = accept;
      o_tag_wr_rdest  = i_enq_rdest;
      o_tag_wr_tag    = tail_idx;
      o_dest_wr_en    = retire;
      o_dest_wr_rdest = retire ? ent_rdest[head_idx] : {REG_ADDR_WIDTH{1'b0}};
      o_dest_wr_data  = retire ? ent_data[head_idx] : {DATA_WIDTH{1'b0}};
      o_flush         = flush;
      o_redirect_addr = flush ? ent_addr[head_idx] : {ADDR_WIDTH{1'b0}};
    end
  end

  // Operand forwarding: a live CDB broadcast wins over stored entry state.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        o_lookup_rdy[k]  = 1'b0;
        o_lookup_data[k] = {DATA_WIDTH{1'b0}};
      end else if (i_cdb_en && (i_cdb_tag == i_lookup_tag[k])) begin
        o_lookup_rdy[k]  = 1'b1;
        o_lookup_data[k] = i_cdb_data;
      end else if (ent_valid[i_lookup_tag[k]] && ent_rdy[i_lookup_tag[k]]) begin
        o_lookup_rdy[k]  = 1'b1;
        o_lookup_data[k] = ent_data[i_lookup_tag[k]];
      end else begin
        o_lookup_rdy[k]  = 1'b0;
        o_lookup_data[k] = {DATA_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a randomized run checked against
// a queue-based model of in-order allocation, completion and retirement.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        enq_en;
  logic [4:0]  enq_rdest;
  logic        enq_stall;
  logic [5:0]  enq_tag;
  logic        tag_wr_en;
  logic [4:0]  tag_wr_rdest;
  logic [5:0]  tag_wr_tag;
  logic        cdb_en;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_redirect;
  logic [31:0] cdb_addr;
  logic [5:0]  lookup_tag  [2];
  logic        lookup_rdy  [2];
  logic [31:0] lookup_data [2];
  logic        dest_wr_en;
  logic [4:0]  dest_wr_rdest;
  logic [31:0] dest_wr_data;
  logic        flush;
  logic [31:0] redirect_addr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rdest;
    bit          rdy;
    bit          redir;
    logic [31:0] data;
    logic [31:0] addr;
  } ent_t;

  ent_t       q[$];
  logic [5:0] next_tag;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .i_enq_en(enq_en), .i_enq_rdest(enq_rdest),
    .o_enq_stall(enq_stall), .o_enq_tag(enq_tag),
    .o_tag_wr_en(tag_wr_en), .o_tag_wr_rdest(tag_wr_rdest), .o_tag_wr_tag(tag_wr_tag),
    .i_cdb_en(cdb_en), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .i_cdb_redirect(cdb_redirect), .i_cdb_addr(cdb_addr),
    .i_lookup_tag(lookup_tag), .o_lookup_rdy(lookup_rdy), .o_lookup_data(lookup_data),
    .o_dest_wr_en(dest_wr_en), .o_dest_wr_rdest(dest_wr_rdest), .o_dest_wr_data(dest_wr_data),
    .o_flush(flush), .o_redirect_addr(redirect_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    enq_en = 1'b0; enq_rdest = 5'd0;
    cdb_en = 1'b0; cdb_tag = 6'd0; cdb_data = 32'd0; cdb_redirect = 1'b0; cdb_addr = 32'd0;
    lookup_tag[0] = 6'd0; lookup_tag[1] = 6'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic enq(input logic [4:0] rd);
    enq_en = 1'b1; enq_rdest = rd;
    tick();
    enq_en = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d, input logic rd, input logic [31:0] a);
    cdb_en = 1'b1; cdb_tag = t; cdb_data = d; cdb_redirect = rd; cdb_addr = a;
    tick();
    cdb_en = 1'b0; cdb_redirect = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; enq_en = 1'b1; enq_rdest = 5'd9;
    #1;
    vectors++; if (tag_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_tag_wr_en: got %0h want 0", tag_wr_en); end
    vectors++; if (enq_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0h want 0", enq_stall); end
    vectors++; if (dest_wr_en !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL reset_retire: got %0h/%0h want 0/0", dest_wr_en, flush); end
    vectors++; if (tag_wr_rdest !== 5'd0) begin miscompares++; $display("FAIL reset_tag_wr_rdest: got %0h want 0", tag_wr_rdest); end
    tick();
    rst = 1'b0; idle();
    enq_en = 1'b1; enq_rdest = 5'd5; lookup_tag[0] = 6'd0;
    #1;
    vectors++; if (tag_wr_en !== 1'b1) begin miscompares++; $display("FAIL enq_tag_wr_en: got %0h want 1", tag_wr_en); end
    vectors++; if (tag_wr_tag !== 6'd0 || enq_tag !== 6'd0) begin miscompares++; $display("FAIL enq_tag: got %0h/%0h want 0", tag_wr_tag, enq_tag); end
    vectors++; if (tag_wr_rdest !== 5'd5) begin miscompares++; $display("FAIL enq_rdest: got %0h want 5", tag_wr_rdest); end
    vectors++; if (enq_stall !== 1'b0) begin miscompares++; $display("FAIL enq_stall: got %0h want 0", enq_stall); end
    tick();
    enq_en = 1'b0;
    #1;
    vectors++; if (lookup_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL lookup_pending: got %0h want 0", lookup_rdy[0]); end
    vectors++; if (enq_tag !== 6'd1) begin miscompares++; $display("FAIL enq_tag_next: got %0h want 1", enq_tag); end
  endtask

  task automatic test_in_order();
    do_reset();
    enq(5'd7);
    enq(5'd9);
    cdb_en = 1'b1; cdb_tag = 6'd1; cdb_data = 32'hBEEF;
    #1;
    vectors++; if (dest_wr_en !== 1'b0) begin miscompares++; $display("FAIL order_no_early: got %0h want 0", dest_wr_en); end
    tick();
    cdb_tag = 6'd0; cdb_data = 32'h1234;
    #1;
    vectors++; if (dest_wr_en !== 1'b0) begin miscompares++; $display("FAIL order_same_cycle: got %0h want 0", dest_wr_en); end
    tick();
    idle();
    #1;
    vectors++; if ({dest_wr_en, dest_wr_rdest, dest_wr_data} !== {1'b1, 5'd7, 32'h1234}) begin miscompares++; $display("FAIL order_first: got %0h/%0h/%0h want 1/7/1234", dest_wr_en, dest_wr_rdest, dest_wr_data); end
    tick();
    vectors++; if ({dest_wr_en, dest_wr_rdest, dest_wr_data} !== {1'b1, 5'd9, 32'hBEEF}) begin miscompares++; $display("FAIL order_second: got %0h/%0h/%0h want 1/9/beef", dest_wr_en, dest_wr_rdest, dest_wr_data); end
    tick();
    vectors++; if (dest_wr_en !== 1'b0) begin miscompares++; $display("FAIL order_drained: got %0h want 0", dest_wr_en); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) enq(5'(i + 1));
    lookup_tag[0] = 6'd3; lookup_tag[1] = 6'd2;
    cdb_en = 1'b1; cdb_tag = 6'd3; cdb_data = 32'hAA;
    #1;
    vectors++; if (lookup_rdy[0] !== 1'b1 || lookup_data[0] !== 32'hAA) begin miscompares++; $display("FAIL bypass_hit: got %0h/%0h want 1/aa", lookup_rdy[0], lookup_data[0]); end
    vectors++; if (lookup_rdy[1] !== 1'b0) begin miscompares++; $display("FAIL bypass_other: got %0h want 0", lookup_rdy[1]); end
    tick();
    cdb_en = 1'b0;
    #1;
    vectors++; if (lookup_rdy[0] !== 1'b1 || lookup_data[0] !== 32'hAA) begin miscompares++; $display("FAIL stored_fwd: got %0h/%0h want 1/aa", lookup_rdy[0], lookup_data[0]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      enq_en = 1'b1; enq_rdest = 5'(i);
      #1;
      vectors++; if (enq_tag !== 6'(i) || tag_wr_en !== 1'b1 || enq_stall !== 1'b0) begin miscompares++; $display("FAIL fill_%0d: got tag %0h en %0h stall %0h", i, enq_tag, tag_wr_en, enq_stall); end
      tick();
    end
    enq_rdest = 5'd3;
    #1;
    vectors++; if (enq_stall !== 1'b1 || tag_wr_en !== 1'b0) begin miscompares++; $display("FAIL full_stall: got stall %0h en %0h want 1/0", enq_stall, tag_wr_en); end
    tick();
    vectors++; if (enq_stall !== 1'b1 || enq_tag !== 6'd0) begin miscompares++; $display("FAIL full_tail_held: got stall %0h tag %0h want 1/0", enq_stall, enq_tag); end
    cdb(6'd0, 32'h55, 1'b0, 32'd0);
    #1;
    vectors++; if (dest_wr_en !== 1'b1 || enq_stall !== 1'b1 || tag_wr_en !== 1'b0) begin miscompares++; $display("FAIL full_retire: got ret %0h stall %0h en %0h want 1/1/0", dest_wr_en, enq_stall, tag_wr_en); end
    tick();
    vectors++; if (enq_stall !== 1'b0 || tag_wr_en !== 1'b1 || enq_tag !== 6'd0) begin miscompares++; $display("FAIL wrap_enq: got stall %0h en %0h tag %0h want 0/1/0", enq_stall, tag_wr_en, enq_tag); end
    tick();
    vectors++; if (enq_stall !== 1'b1) begin miscompares++; $display("FAIL refull: got %0h want 1", enq_stall); end
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 6; i++) enq(5'(10 + i));
    cdb(6'd0, 32'h100, 1'b0, 32'd0);
    cdb_en = 1'b1; cdb_tag = 6'd1; cdb_data = 32'h101;
    #1;
    vectors++; if (dest_wr_en !== 1'b1 || dest_wr_rdest !== 5'd10 || flush !== 1'b0) begin miscompares++; $display("FAIL redir_pre0: got %0h/%0h/%0h want 1/a/0", dest_wr_en, dest_wr_rdest, flush); end
    tick();
    cdb_tag = 6'd2; cdb_data = 32'h22; cdb_redirect = 1'b1; cdb_addr = 32'h400;
    #1;
    vectors++; if (flush !== 1'b0 || dest_wr_rdest !== 5'd11) begin miscompares++; $display("FAIL redir_pre1: got flush %0h rd %0h want 0/b", flush, dest_wr_rdest); end
    tick();
    cdb_tag = 6'd4; cdb_data = 32'h44; cdb_redirect = 1'b0; cdb_addr = 32'd0;
    enq_en = 1'b1; enq_rdest = 5'd20;
    #1;
    vectors++; if (flush !== 1'b1 || redirect_addr !== 32'h400) begin miscompares++; $display("FAIL redir_flush: got %0h/%0h want 1/400", flush, redirect_addr); end
    vectors++; if ({dest_wr_en, dest_wr_rdest, dest_wr_data} !== {1'b1, 5'd12, 32'h22}) begin miscompares++; $display("FAIL redir_dest: got %0h/%0h/%0h want 1/c/22", dest_wr_en, dest_wr_rdest, dest_wr_data); end
    vectors++; if (tag_wr_en !== 1'b0) begin miscompares++; $display("FAIL redir_enq_drop: got %0h want 0", tag_wr_en); end
    tick();
    idle(); lookup_tag[0] = 6'd4;
    #1;
    vectors++; if (flush !== 1'b0 || dest_wr_en !== 1'b0) begin miscompares++; $display("FAIL post_flush: got %0h/%0h want 0/0", flush, dest_wr_en); end
    vectors++; if (enq_tag !== 6'd0 || enq_stall !== 1'b0 || lookup_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL post_flush_empty: got tag %0h stall %0h rdy %0h", enq_tag, enq_stall, lookup_rdy[0]); end
    enq_en = 1'b1; enq_rdest = 5'd21;
    #1;
    vectors++; if (tag_wr_en !== 1'b1 || tag_wr_tag !== 6'd0) begin miscompares++; $display("FAIL post_flush_enq: got %0h/%0h want 1/0", tag_wr_en, tag_wr_tag); end
    tick();
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) enq(5'(i + 1));
    cdb(6'd1, 32'h11, 1'b0, 32'd0);
    cdb(6'd2, 32'h12, 1'b0, 32'd0);
    cdb(6'd0, 32'h10, 1'b0, 32'd0);
    #1;
    vectors++; if (dest_wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %0h want 1", dest_wr_en); end
    rst = 1'b1; enq_en = 1'b1; enq_rdest = 5'd6; lookup_tag[0] = 6'd1;
    cdb_en = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h77;
    #1;
    vectors++; if (dest_wr_en !== 1'b0 || tag_wr_en !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out: got %0h/%0h/%0h want 0/0/0", dest_wr_en, tag_wr_en, flush); end
    vectors++; if (lookup_rdy[0] !== 1'b0 || enq_stall !== 1'b0 || dest_wr_data !== 32'd0) begin miscompares++; $display("FAIL mid_rst_misc: got %0h/%0h/%0h want 0/0/0", lookup_rdy[0], enq_stall, dest_wr_data); end
    tick();
    rst = 1'b0; idle(); lookup_tag[0] = 6'd1;
    #1;
    vectors++; if (dest_wr_en !== 1'b0 || lookup_rdy[0] !== 1'b0 || enq_tag !== 6'd0) begin miscompares++; $display("FAIL mid_release: got %0h/%0h/%0h want 0/0/0", dest_wr_en, lookup_rdy[0], enq_tag); end
    tick();
    vectors++; if (dest_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_no_retire: got %0h want 0", dest_wr_en); end
  endtask

  task automatic test_random();
    ent_t        ent;
    bit          e_full, e_ret, e_flush, e_acc, e_lrdy;
    logic [31:0] e_ldata;
    do_reset();
    q.delete();
    next_tag = 6'd0;
    for (int c = 0; c < 3000; c++) begin
      enq_en    = ($urandom_range(0, 99) < 60);
      enq_rdest = 5'($urandom_range(0, 31));
      cdb_en    = ($urandom_range(0, 99) < 50);
      if (q.size() > 0 && $urandom_range(0, 9) != 0) cdb_tag = q[$urandom_range(0, q.size() - 1)].tag;
      else cdb_tag = 6'($urandom_range(0, 63));
      cdb_data     = $urandom;
      cdb_redirect = ($urandom_range(0, 39) == 0);
      cdb_addr     = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0) lookup_tag[k] = q[$urandom_range(0, q.size() - 1)].tag;
        else lookup_tag[k] = 6'($urandom_range(0, 63));
      end
      #1;
      e_full  = (q.size() == 64);
      e_ret   = (q.size() > 0) && q[0].rdy;
      e_flush = e_ret && q[0].redir;
      e_acc   = enq_en && !e_full && !e_flush;
      vectors++; if (enq_stall !== e_full) begin miscompares++; $display("FAIL rnd_stall c%0d: got %0h want %0h", c, enq_stall, e_full); end
      vectors++; if (enq_tag !== next_tag || tag_wr_tag !== next_tag) begin miscompares++; $display("FAIL rnd_tag c%0d: got %0h/%0h want %0h", c, enq_tag, tag_wr_tag, next_tag); end
      vectors++; if (tag_wr_en !== e_acc || tag_wr_rdest !== enq_rdest) begin miscompares++; $display("FAIL rnd_tag_wr c%0d: got %0h/%0h want %0h/%0h", c, tag_wr_en, tag_wr_rdest, e_acc, enq_rdest); end
      vectors++; if (dest_wr_en !== e_ret || flush !== e_flush) begin miscompares++; $display("FAIL rnd_retire c%0d: got %0h/%0h want %0h/%0h", c, dest_wr_en, flush, e_ret, e_flush); end
      if (e_ret) begin
        vectors++; if (dest_wr_rdest !== q[0].rdest || dest_wr_data !== q[0].data) begin miscompares++; $display("FAIL rnd_dest c%0d: got %0h/%0h want %0h/%0h", c, dest_wr_rdest, dest_wr_data, q[0].rdest, q[0].data); end
      end
      if (e_flush) begin
        vectors++; if (redirect_addr !== q[0].addr) begin miscompares++; $display("FAIL rnd_redirect c%0d: got %0h want %0h", c, redirect_addr, q[0].addr); end
      end
      for (int k = 0; k < 2; k++) begin
        e_lrdy = 1'b0; e_ldata = 32'd0;
        if (cdb_en && cdb_tag == lookup_tag[k]) begin
          e_lrdy = 1'b1; e_ldata = cdb_data;
        end else begin
          foreach (q[j]) if (q[j].tag == lookup_tag[k] && q[j].rdy) begin e_lrdy = 1'b1; e_ldata = q[j].data; end
        end
        vectors++; if (lookup_rdy[k] !== e_lrdy || (e_lrdy && lookup_data[k] !== e_ldata)) begin miscompares++; $display("FAIL rnd_lookup%0d c%0d: got %0h/%0h want %0h/%0h", k, c, lookup_rdy[k], lookup_data[k], e_lrdy, e_ldata); end
      end
      if (e_flush) begin
        q.delete();
        next_tag = 6'd0;
      end else begin
        if (cdb_en) begin
          foreach (q[j]) if (q[j].tag == cdb_tag) begin
            q[j].rdy = 1'b1; q[j].redir = cdb_redirect; q[j].data = cdb_data; q[j].addr = cdb_addr;
          end
        end
        if (e_ret) void'(q.pop_front());
        if (e_acc) begin
          ent.tag = next_tag; ent.rdest = enq_rdest; ent.rdy = 1'b0; ent.redir = 1'b0;
          ent.data = 32'd0; ent.addr = 32'd0;
          q.push_back(ent);
          next_tag = next_tag + 6'd1;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    test_reset();
    test_in_order();
    test_bypass();
    test_full();
    test_redirect();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
